ones_run_sched: RTL and testbench
=================================

# ones_run_sched

Round-robin scheduler that shares one serial run-of-ones detector among `N_CH` serial channels. A channel requests a frame. The scheduler grants exactly one channel at a time for `FRAME_LEN` bit periods and feeds that channel's bit into the internal detector, which is a Moore "at least `RUN_LEN` consecutive ones" machine. At the end of each frame it reports a per-frame summary. The block sits between the channel front-ends and the frame-statistics logic, replacing one detector per channel.

## Interface
Parameters:
- `N_CH`, 4, number of serial channels (≥2)
- `FRAME_LEN`, 8, bits examined per granted frame (≥2)
- `RUN_LEN`, 3, consecutive ones needed for detection (≥1, ≤`FRAME_LEN`)
- `CW`, `$clog2(N_CH)`, channel-index width (derived, not overridden)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: **synchronous, active-high** reset
- `req` in `N_CH`: per-channel frame request, level
- `data_in` in `N_CH`: per-channel serial bit, one bit per cycle
- `grant` out `N_CH`: one-hot grant; all-zero when no frame is running
- `busy` out 1: high in RUN
- `detect` out 1: Moore output of the shared detector; run count ≥ `RUN_LEN`
- `done` out 1: one-cycle pulse at frame end
- `done_ch` out `CW`: channel of the finished frame, valid with `done`
- `hit` out 1: at least one detection occurred in the frame, valid with `done`
- `abort` out 1: frame ended early, valid with `done`

## Operation
- States: IDLE, RUN, REPORT.
- Registered state: `ptr` (last winner), `cur` (granted channel), bit counter (0..`FRAME_LEN`-1), run counter (saturates at `RUN_LEN`), sticky `hit_r`.
- **IDLE**
  - If `req` == 0: stay in IDLE.
  - Otherwise select the winner: the first channel with `req` set, scanning `ptr+1`, `ptr+2`, … modulo `N_CH`.
  - Load `cur`, set `ptr` = winner, clear both counters and `hit_r`, then go to RUN.
- **RUN**
  - `grant` = one-hot(`cur`).
  - Each cycle, sample `data_in[cur]`:
    - If the bit is 1, the run counter increments and saturates at `RUN_LEN`.
    - If the bit is 0, the run counter clears.
    - The bit counter increments.
  - When the run counter reaches `RUN_LEN`, set `hit_r`.
  - If the sampled bit is the `FRAME_LEN`-th bit (bit counter = `FRAME_LEN`-1), go to REPORT with `abort` = 0.
  - If `req[cur]` is 0 in a RUN cycle:
    - That cycle's bit is not counted.
    - Go to REPORT with `abort` = 1.
    - `hit` reports detections so far.
  - Requests from other channels are ignored during RUN; there is no preemption.
- **REPORT**
  - `done` = 1 for exactly one cycle.
  - `done_ch` = `cur`, `hit` = `hit_r`, `abort` as latched.
  - `grant` = 0; run counter cleared.
  - Next state: IDLE, always.
- `detect` = (run counter == `RUN_LEN`), gated by RUN. It stays high while consecutive ones continue and drops the cycle after a 0 is sampled.
- Reset values:
  - State = IDLE, `ptr` = `N_CH`-1, so channel 0 wins first after reset.
  - All counters, `cur`, and `hit_r` are 0.
  - All outputs are 0.
  - Reset asserted mid-frame abandons the frame with no `done` pulse.

## Timing
- Request to grant: `req` seen high in an IDLE cycle → `grant` high from the next cycle.
- Bits are sampled on the `FRAME_LEN` rising edges while `grant` is high. Bit k (0-based) is sampled at the end of grant cycle k.
- Detection latency: the Moore output rises one cycle after the sample that completes the run.
- `done` occurs in the cycle after the last sample; `grant` is already low in that cycle.
- Back-to-back frames: REPORT → IDLE → RUN. Minimum frame period is `FRAME_LEN`+2 cycles.
- Simultaneous events:
  - `req` rising in a REPORT cycle is considered in the following IDLE cycle.
  - A detection and `req[cur]` falling in the same cycle: the abort wins, and that bit is not counted.
- All outputs are registered or decoded from registered state. No combinational path from `req`/`data_in` to any output.

## Test plan
1. **Reset and single frame.** Reset 2 cycles, then `req`=4'b0001; ch0 bits 0,1,1,1,1,0,0,0.
   - Required: `grant`=0001 for 8 cycles; `detect` high after bits 3 and 4.
   - Then `done`=1, `done_ch`=0, `hit`=1, `abort`=0.
2. **No run.** ch2 alone requesting, bits 1,1,0,1,1,0,1,1.
   - Required: `detect` never high; `done` with `done_ch`=2, `hit`=0.
3. **Round robin.** `req`=4'b1111 held continuously.
   - Required: grant order ch0, ch1, ch2, ch3, ch0, with a frame period of 10 cycles at default parameters.
4. **Abort.** Drop `req[cur]` after 4 sampled bits 1,1,1,1.
   - Required: next cycle `done`=1, `abort`=1, `hit`=1; `grant` low.
   - The next requester wins after one IDLE cycle.
5. **Mid-frame reset.** Assert `reset` at bit 5 of a frame.
   - Required: next cycle all outputs 0 and no `done` pulse.
   - Next grant goes to the lowest requesting channel (`ptr`=3).
6. **Parameter sweep.** `RUN_LEN`=1 and `RUN_LEN`=`FRAME_LEN`=8.
   - All-ones input: `hit`=1 in both cases.
   - `RUN_LEN`=8: `detect` asserts only in the REPORT-preceding cycle after bit 7, i.e. gated to 0 since the state is REPORT. `hit` is still 1.

Source files
------------

// File: rtl/ones_run_sched.sv
// ones_run_sched: round-robin scheduler sharing one serial run-of-ones
// detector among N_CH channels. One channel is granted for FRAME_LEN bit
// periods; a one-cycle summary (done/done_ch/hit/abort) follows every frame.
//
// Handshake: req[i] is a level request. A channel is granted when the block
// is idle and it wins the round-robin scan; the frame runs while req[cur]
// stays high. Dropping req[cur] during a frame ends it early (abort) and the
// bit presented in that cycle is discarded. done is a single-cycle pulse with
// done_ch/hit/abort valid only alongside it; there is no back-pressure.
module ones_run_sched #(
  parameter int N_CH      = 4,
  parameter int FRAME_LEN = 8,
  parameter int RUN_LEN   = 3,
  localparam int CW       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] data_in,
  output logic [N_CH-1:0] grant,
  output logic            busy,
  output logic            detect,
  output logic            done,
  output logic [CW-1:0]   done_ch,
  output logic            hit,
  output logic            abort,
  output logic [1:0]      dbg_state_o
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] run_q, run_d;
  logic          hit_q, hit_d;
  logic          abort_q, abort_d;

  logic [CW-1:0] win;
  logic          win_vld;

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin : arb
    int idx;
    logic [CW-1:0] cand;
    idx     = 0;
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx  = (int'(ptr_q) + i) % N_CH;
      cand = CW'(idx);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, bit/run counting in RUN,
  // single report cycle afterwards.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    bit_d   = bit_q;
    run_d   = run_q;
    hit_d   = hit_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          cur_d   = win;
          ptr_d   = win;
          bit_d   = '0;
          run_d   = '0;
          hit_d   = 1'b0;
          abort_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[cur_q]) begin
          // Early end: this cycle's bit is dropped, counters keep their value.
          abort_d = 1'b1;
          state_d = S_REPORT;
        end else begin
          if (data_in[cur_q]) begin
            if (run_q != RW'(RUN_LEN)) run_d = run_q + 1'b1;
          end else begin
            run_d = '0;
          end
          // Use the updated count so a run completed by the last bit still hits.
          if (run_d == RW'(RUN_LEN)) hit_d = 1'b1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(FRAME_LEN - 1)) begin
            abort_d = 1'b0;
            state_d = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        run_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; ptr starts at the last channel so
  // channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= CW'(N_CH - 1);
      cur_q   <= '0;
      bit_q   <= '0;
      run_q   <= '0;
      hit_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      bit_q   <= bit_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      abort_q <= abort_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_REPORT);
  assign grant       = busy ? (ONE_HOT0 << cur_q) : '0;
  assign detect      = busy && (run_q == RW'(RUN_LEN));
  assign done_ch     = done ? cur_q : '0;
  assign hit         = done & hit_q;
  assign abort       = done & abort_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ones_run_sched.sv
// Bench for ones_run_sched: three instances (RUN_LEN 3, 1, 8) share one
// directed stimulus; a frame-level model predicts every output each cycle.
module tb_ones_run_sched;

  localparam int N_CH      = 4;
  localparam int FRAME_LEN = 8;
  localparam int CW        = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] data_in;

  logic [N_CH-1:0] grant   [3];
  logic            busy    [3];
  logic            detect  [3];
  logic            done    [3];
  logic [CW-1:0]   done_ch [3];
  logic            hit     [3];
  logic            abort   [3];
  logic [1:0]      dbg     [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ones_run_sched #(.N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .RUN_LEN(3)) u_r3 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant[0]), .busy(busy[0]), .detect(detect[0]), .done(done[0]),
    .done_ch(done_ch[0]), .hit(hit[0]), .abort(abort[0]), .dbg_state_o(dbg[0]));

  ones_run_sched #(.N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .RUN_LEN(1)) u_r1 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant[1]), .busy(busy[1]), .detect(detect[1]), .done(done[1]),
    .done_ch(done_ch[1]), .hit(hit[1]), .abort(abort[1]), .dbg_state_o(dbg[1]));

  ones_run_sched #(.N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .RUN_LEN(8)) u_r8 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant[2]), .busy(busy[2]), .detect(detect[2]), .done(done[2]),
    .done_ch(done_ch[2]), .hit(hit[2]), .abort(abort[2]), .dbg_state_o(dbg[2]));

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // phase: 0 waiting, 1 frame in progress, 2 summary cycle
  int            m_phase = 0;
  int            m_ptr   = N_CH - 1;
  int            m_cur   = 0;
  logic          m_abort = 1'b0;
  logic          m_bits[$];
  logic [CW-1:0] exp_q[$];
  int            rl[3] = '{3, 1, 8};

  function automatic int trail_ones();
    int n = 0;
    int i = m_bits.size() - 1;
    while (i >= 0 && m_bits[i] == 1'b1) begin
      n++;
      i--;
    end
    return n;
  endfunction

  function automatic int longest_run();
    int n = 0;
    int best = 0;
    foreach (m_bits[i]) begin
      if (m_bits[i]) n++; else n = 0;
      if (n > best) best = n;
    end
    return best;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_ptr = N_CH - 1; m_cur = 0; m_abort = 1'b0;
      m_bits.delete();
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          bit found;
          found = 1'b0;
          for (int i = 1; i <= N_CH; i++) begin
            if (!found && req[(m_ptr + i) % N_CH]) begin
              m_cur = (m_ptr + i) % N_CH;
              found = 1'b1;
            end
          end
          m_ptr = m_cur;
          m_bits.delete();
          exp_q.push_back(CW'(m_cur));
          m_phase = 1;
        end
        1: if (!req[m_cur]) begin
          m_abort = 1'b1;
          m_phase = 2;
        end else begin
          m_bits.push_back(data_in[m_cur]);
          if (m_bits.size() == FRAME_LEN) begin
            m_abort = 1'b0;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic [10:0] exp_m, act_m;
  logic [1:0]  exp_s, act_s;
  logic [CW-1:0] q_ch;
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_m = {((m_phase == 1) ? 4'(1 << m_cur) : 4'b0),
               (m_phase == 1),
               ((m_phase == 1) && (trail_ones() >= rl[0])),
               (m_phase == 2),
               ((m_phase == 2) ? 2'(m_cur) : 2'b0),
               ((m_phase == 2) && (longest_run() >= rl[0])),
               ((m_phase == 2) && m_abort)};
      act_m = {grant[0], busy[0], detect[0], done[0], done_ch[0], hit[0], abort[0]};
      check("cycle_r3", 32'(act_m), 32'(exp_m));
      for (int k = 1; k < 3; k++) begin
        exp_s = {((m_phase == 1) && (trail_ones() >= rl[k])),
                 ((m_phase == 2) && (longest_run() >= rl[k]))};
        act_s = {detect[k], hit[k]};
        check((k == 1) ? "cycle_r1" : "cycle_r8", 32'(act_s), 32'(exp_s));
      end
      if (done[0] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'(1), 32'(0));
        end else begin
          q_ch = exp_q.pop_front();
          check("sb_done_ch", 32'(done_ch[0]), 32'(q_ch));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Requests channel ch (plus 'extra'), feeds bits b[k] in grant cycle k and
  // drops req[ch] in cycle 'drop' (-1: never). Returns in the cycle after the
  // last sampled cycle, with detect captured per grant cycle.
  task automatic frame(input int ch, input logic [7:0] b, input int drop,
                       input logic [N_CH-1:0] extra,
                       output logic [7:0] det, output logic [7:0] det8, output bit ok);
    int n;
    ok = 1'b0; det = '0; det8 = '0; n = 0;
    @(negedge clk);
    req = req | extra;
    req[ch] = 1'b1;
    data_in = 4'($urandom); data_in[ch] = b[0];
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (grant[0][ch] === 1'b1) ok = 1'b1;
      else begin data_in = 4'($urandom); data_in[ch] = b[0]; end
    end
    if (!ok) begin
      check("grant_wait", 32'(0), 32'(1));
      return;
    end
    for (int k = 0; k < FRAME_LEN; k++) begin
      det[k] = detect[0]; det8[k] = detect[2];
      data_in = 4'($urandom); data_in[ch] = b[k];
      if (k == drop) req[ch] = 1'b0;
      @(negedge clk);
      if (k == drop) break;
    end
  endtask

  task automatic quiesce();
    bit idle;
    idle = 1'b0;
    req = '0;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      if (busy[0] === 1'b0 && done[0] === 1'b0) idle = 1'b1;
    end
    if (!idle) check("quiesce_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] det, det8;
  bit ok;
  int rr_ch[5];
  int rr_t[5];
  int rr_n;
  logic [N_CH-1:0] prev_g;

  initial begin
    req = '0; data_in = '0; reset = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_outputs", 32'({grant[0], busy[0], detect[0], done[0], done_ch[0], hit[0], abort[0]}), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // 1: single frame on ch0, bits 0,1,1,1,1,0,0,0
    frame(0, 8'b0001_1110, -1, '0, det, det8, ok);
    check("t1_detect_pattern", 32'(det), 32'(8'b0011_0000));
    check("t1_done", 32'(done[0]), 32'(1));
    check("t1_done_ch", 32'(done_ch[0]), 32'(0));
    check("t1_hit", 32'(hit[0]), 32'(1));
    check("t1_abort", 32'(abort[0]), 32'(0));
    check("t1_grant_low", 32'(grant[0]), 32'(0));
    check("t1_hit_r1", 32'(hit[1]), 32'(1));
    check("t1_hit_r8", 32'(hit[2]), 32'(0));
    req[0] = 1'b0;

    // 2: no run of three on ch2, bits 1,1,0,1,1,0,1,1
    frame(2, 8'b1101_1011, -1, '0, det, det8, ok);
    check("t2_detect_never", 32'(det), 32'(0));
    check("t2_done", 32'(done[0]), 32'(1));
    check("t2_done_ch", 32'(done_ch[0]), 32'(2));
    check("t2_hit", 32'(hit[0]), 32'(0));
    req[2] = 1'b0;

    // 4: abort on ch3 after 1,1,1,1 while ch1 waits
    frame(3, 8'b0000_1111, 4, 4'b0010, det, det8, ok);
    check("t4_detect_pattern", 32'(det), 32'(8'b0001_1000));
    check("t4_done", 32'(done[0]), 32'(1));
    check("t4_abort", 32'(abort[0]), 32'(1));
    check("t4_hit", 32'(hit[0]), 32'(1));
    check("t4_done_ch", 32'(done_ch[0]), 32'(3));
    check("t4_grant_low", 32'(grant[0]), 32'(0));
    @(negedge clk);
    check("t4_idle_gap", 32'({grant[0], busy[0]}), 32'(0));
    @(negedge clk);
    check("t4_next_grant", 32'(grant[0]), 32'(4'b0010));
    quiesce();

    // 5: reset during bit 5 of a ch2 frame
    @(negedge clk);
    req = 4'b0110;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (grant[0] === 4'b0100) ok = 1'b1;
    end
    check("t5_first_grant", 32'(ok), 32'(1));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", 32'({grant[0], busy[0], detect[0], done[0], done_ch[0], hit[0], abort[0]}), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("t5_grant_after_reset", 32'(grant[0]), 32'(4'b0010));
    quiesce();

    // 3: round robin with all requests held, starting from reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'hF;
    rr_n = 0; prev_g = '0;
    for (int c = 0; c < 80 && rr_n < 5; c++) begin
      @(negedge clk);
      data_in = 4'($urandom);
      if (grant[0] != '0 && prev_g == '0) begin
        for (int i = 0; i < N_CH; i++) if (grant[0][i]) rr_ch[rr_n] = i;
        rr_t[rr_n] = c;
        rr_n++;
      end
      prev_g = grant[0];
    end
    check("t3_frames_seen", 32'(rr_n), 32'(5));
    if (rr_n == 5) begin
      for (int i = 0; i < 5; i++) check("t3_order", 32'(rr_ch[i]), 32'(i % N_CH));
      for (int i = 1; i < 5; i++) check("t3_period", 32'(rr_t[i] - rr_t[i-1]), 32'(10));
    end
    quiesce();

    // 6: all-ones frame for RUN_LEN 3, 1 and 8
    frame(1, 8'hFF, -1, '0, det, det8, ok);
    check("t6_detect_r3", 32'(det), 32'(8'b1111_1000));
    check("t6_detect_r8_gated", 32'(det8), 32'(0));
    check("t6_hit_r3", 32'(hit[0]), 32'(1));
    check("t6_hit_r1", 32'(hit[1]), 32'(1));
    check("t6_hit_r8", 32'(hit[2]), 32'(1));
    check("t6_done_r8", 32'(done[2]), 32'(1));
    req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
